// File: rtl/synth_pkg.sv
// Shared state type, default widths and helpers for the voice synthesis datapath.
package synth_pkg;

  localparam int unsigned DEF_PHASE_WIDTH = 32;
  localparam int unsigned DEF_DATA_WIDTH  = 16;
  localparam int unsigned DEF_ENV_WIDTH   = 16;

  typedef logic [DEF_DATA_WIDTH-1:0] sample_t;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StDrain,
    StNorm,
    StDone
  } mix_state_e;

  // Ceiling log2; 0 and 1 both map to 0.
  function automatic int unsigned clog2_u(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/voice_mac.sv
// Registered envelope multiply, then gate-qualified accumulate and active-voice count.
module voice_mac #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ENV_WIDTH  = 16,
  parameter int unsigned ACC_WIDTH  = 19,
  parameter int unsigned CNT_WIDTH  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  valid_i,
  input  logic                  gate_i,
  input  logic [ENV_WIDTH-1:0]  env_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [ACC_WIDTH-1:0]  acc_o,
  output logic [CNT_WIDTH-1:0]  count_o
);

  logic [DATA_WIDTH+ENV_WIDTH-1:0] mult;
  logic [DATA_WIDTH-1:0]           prod_q;
  logic                            prod_en_q;
  logic [ACC_WIDTH-1:0]            acc_q;
  logic [CNT_WIDTH-1:0]            cnt_q;

  assign mult = {{ENV_WIDTH{1'b0}}, data_i} * {{DATA_WIDTH{1'b0}}, env_i};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prod_q    <= '0;
      prod_en_q <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
    end else begin
      prod_q    <= DATA_WIDTH'(mult >> ENV_WIDTH);
      prod_en_q <= valid_i & gate_i & ~clear_i;
      if (clear_i) begin
        acc_q <= '0;
        cnt_q <= '0;
      end else if (prod_en_q) begin
        acc_q <= acc_q + ACC_WIDTH'(prod_q);
        cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign acc_o   = acc_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/poly_voice_mixer.sv
// Time-multiplexed polyphonic mixer sharing one sine-table port across all voices per tick.
// Define MIXER_AUTO_GAIN_EN to normalise by the active voice count instead of NUM_VOICES.
module poly_voice_mixer
  import synth_pkg::*;
#(
  parameter int unsigned NUM_VOICES  = 8,
  parameter int unsigned PHASE_WIDTH = DEF_PHASE_WIDTH,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned ENV_WIDTH   = DEF_ENV_WIDTH,
  parameter int unsigned RAM_LATENCY = 2,
  localparam int unsigned CntW       = $clog2(NUM_VOICES + 1)
) (
  input  logic                                  clk_in,
  input  logic                                  rst_in,
  input  logic                                  sample_tick,
  input  logic [NUM_VOICES-1:0][PHASE_WIDTH-1:0] phase_in,
  input  logic [NUM_VOICES-1:0]                 gate_in,
  input  logic [NUM_VOICES-1:0][ENV_WIDTH-1:0]  env_in,
  output logic [ADDR_WIDTH-1:0]                 addr_out,
  input  logic [DATA_WIDTH-1:0]                 rd_data_in,
  output logic [DATA_WIDTH-1:0]                 sample_out,
  output logic                                  sample_valid_out,
  output logic [CntW-1:0]                       active_count_out,
  output logic                                  busy_out,
  output logic                                  overrun_out
);

  localparam int unsigned VoiceW     = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int unsigned DrainW     = $clog2(RAM_LATENCY + 1);
  localparam int unsigned AccW       = DATA_WIDTH + $clog2(NUM_VOICES);
  localparam int unsigned FixedShift = $clog2(NUM_VOICES);
  localparam logic [VoiceW-1:0] LastVoice = VoiceW'(NUM_VOICES - 1);
  localparam logic [DrainW-1:0] LastDrain = DrainW'(RAM_LATENCY);

  mix_state_e state_q, state_d;
  logic [VoiceW-1:0] voice_q, voice_d;
  logic [DrainW-1:0] drain_q, drain_d;
  logic              tick_accept;
  logic              issue;
  logic [ADDR_WIDTH-1:0] cur_addr, addr_hold_q;

  // Gate/envelope/valid delay line aligning each voice with its table read.
  logic [RAM_LATENCY-1:0]                vld_dly_q, gate_dly_q;
  logic [RAM_LATENCY-1:0][ENV_WIDTH-1:0] env_dly_q;

  logic [AccW-1:0]       acc;
  logic [CntW-1:0]       count;
  logic [DATA_WIDTH-1:0] norm_sample, sample_q;
  logic [CntW-1:0]       active_q;
  logic                  valid_q, overrun_q;
  logic                  unused_phase_bits;

  assign issue             = (state_q == StIssue);
  assign cur_addr          = phase_in[voice_q][PHASE_WIDTH-1 -: ADDR_WIDTH];
  assign unused_phase_bits = ^phase_in;

  always_comb begin
    state_d     = state_q;
    voice_d     = voice_q;
    drain_d     = drain_q;
    tick_accept = 1'b0;
    case (state_q)
      StIdle: begin
        if (sample_tick) begin
          tick_accept = 1'b1;
          voice_d     = '0;
          state_d     = StIssue;
        end
      end
      StIssue: begin
        if (voice_q == LastVoice) begin
          drain_d = '0;
          state_d = StDrain;
        end else begin
          voice_d = voice_q + VoiceW'(1);
        end
      end
      StDrain: begin
        if (drain_q == LastDrain) state_d = StNorm;
        else drain_d = drain_q + DrainW'(1);
      end
      StNorm:  state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    norm_sample = '0;
    if (count != '0) begin
`ifdef MIXER_AUTO_GAIN_EN
      norm_sample = DATA_WIDTH'(acc >> clog2_u(32'(count)));
`else
      norm_sample = DATA_WIDTH'(acc >> FixedShift);
`endif
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= StIdle;
      voice_q     <= '0;
      drain_q     <= '0;
      addr_hold_q <= '0;
      vld_dly_q   <= '0;
      gate_dly_q  <= '0;
      env_dly_q   <= '0;
      sample_q    <= '0;
      active_q    <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      voice_q    <= voice_d;
      drain_q    <= drain_d;
      vld_dly_q  <= RAM_LATENCY'({vld_dly_q, issue});
      gate_dly_q <= RAM_LATENCY'({gate_dly_q, gate_in[voice_q]});
      env_dly_q  <= (RAM_LATENCY * ENV_WIDTH)'({env_dly_q, env_in[voice_q]});
      valid_q    <= (state_q == StNorm);
      if (issue) addr_hold_q <= cur_addr;
      if (state_q == StNorm) begin
        sample_q <= norm_sample;
        active_q <= count;
      end
      if (sample_tick && (state_q != StIdle)) overrun_q <= 1'b1;
    end
  end

  voice_mac #(
    .DATA_WIDTH (DATA_WIDTH),
    .ENV_WIDTH  (ENV_WIDTH),
    .ACC_WIDTH  (AccW),
    .CNT_WIDTH  (CntW)
  ) u_voice_mac (
    .clk_i   (clk_in),
    .rst_i   (rst_in),
    .clear_i (tick_accept),
    .valid_i (vld_dly_q[RAM_LATENCY-1]),
    .gate_i  (gate_dly_q[RAM_LATENCY-1]),
    .env_i   (env_dly_q[RAM_LATENCY-1]),
    .data_i  (rd_data_in),
    .acc_o   (acc),
    .count_o (count)
  );

  assign addr_out         = issue ? cur_addr : addr_hold_q;
  assign sample_out       = sample_q;
  assign sample_valid_out = valid_q;
  assign active_count_out = active_q;
  assign busy_out         = (state_q != StIdle);
  assign overrun_out      = overrun_q;

endmodule

// File: tb/tb_poly_voice_mixer.sv
// Directed bench for poly_voice_mixer with an 8-voice build and a 2-cycle table model.
module tb_poly_voice_mixer;
  import synth_pkg::*;

  localparam int unsigned NV = 8;

`ifdef MIXER_AUTO_GAIN_EN
  localparam bit AutoGain = 1'b1;
`else
  localparam bit AutoGain = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst, sample_tick;
  logic [NV-1:0][31:0]    phase_in;
  logic [NV-1:0]          gate_in;
  logic [NV-1:0][15:0]    env_in;
  logic [7:0]             addr_out;
  sample_t                rd_data, rd_stage, sample_out;
  logic                   sample_valid_out, busy_out, overrun_out;
  logic [3:0]             active_count_out;

  sample_t sine_mem [256];

  always @(posedge clk) begin
    rd_stage <= sine_mem[addr_out];
    rd_data  <= rd_stage;
  end

  poly_voice_mixer #(
    .NUM_VOICES  (NV),
    .PHASE_WIDTH (32),
    .ADDR_WIDTH  (8),
    .DATA_WIDTH  (16),
    .ENV_WIDTH   (16),
    .RAM_LATENCY (2)
  ) dut (
    .clk_in           (clk),
    .rst_in           (rst),
    .sample_tick      (sample_tick),
    .phase_in         (phase_in),
    .gate_in          (gate_in),
    .env_in           (env_in),
    .addr_out         (addr_out),
    .rd_data_in       (rd_data),
    .sample_out       (sample_out),
    .sample_valid_out (sample_valid_out),
    .active_count_out (active_count_out),
    .busy_out         (busy_out),
    .overrun_out      (overrun_out)
  );

  typedef struct {
    logic [7:0]  gate;
    logic [15:0] env;
    logic [7:0]  base;
    logic [15:0] fill;
    logic [15:0] first;
    logic [15:0] exp_auto;
    logic [15:0] exp_fixed;
    logic [3:0]  exp_count;
  } vec_t;

  vec_t vecs [6];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Voice v reads table[base + 16*v]; only table[base] differs from the fill value.
  task automatic load_vec(input vec_t v);
    for (int a = 0; a < 256; a++) sine_mem[a] = v.fill;
    sine_mem[v.base] = v.first;
    for (int i = 0; i < NV; i++) begin
      phase_in[i] = {v.base + 8'(16 * i), 24'hABCDEF};
      env_in[i]   = v.env;
    end
    gate_in = v.gate;
  endtask

  task automatic run_mix(input string tag, input logic [7:0] base, input logic [15:0] exp_sample,
                         input logic [3:0] exp_count, input int extra_tick_k);
    int         valid_k, strobes;
    bit         addr_ok, busy_ok;
    logic [7:0] exp_addr;
    valid_k = -1;
    strobes = 0;
    addr_ok = 1'b1;
    busy_ok = 1'b1;
    @(negedge clk);
    sample_tick = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) sample_tick = 1'b0;
      if (sample_valid_out) begin
        strobes++;
        if (valid_k < 0) valid_k = k;
      end
      exp_addr = (k <= 8) ? base + 8'(16 * (k - 1)) : base + 8'h70;
      if (k <= 13 && addr_out !== exp_addr) addr_ok = 1'b0;
      if (busy_out !== (k <= 13)) busy_ok = 1'b0;
      // Disturb inputs once every voice has issued; the sample in flight must not change.
      if (k == 9) begin
        gate_in = ~gate_in;
        for (int i = 0; i < NV; i++) env_in[i] = 16'h0000;
      end
      if (extra_tick_k != 0 && k == extra_tick_k) sample_tick = 1'b1;
      if (extra_tick_k != 0 && k == extra_tick_k + 1) sample_tick = 1'b0;
    end
    check({tag, ".valid_cycle"}, 32'(valid_k), 32'd13);
    check({tag, ".strobes"}, 32'(strobes), 32'd1);
    check({tag, ".sample"}, 32'(sample_out), 32'(exp_sample));
    check({tag, ".count"}, 32'(active_count_out), 32'(exp_count));
    check({tag, ".addr_seq"}, 32'(addr_ok), 32'd1);
    check({tag, ".busy"}, 32'(busy_ok), 32'd1);
  endtask

  function automatic logic [15:0] pick(input vec_t v);
    return AutoGain ? v.exp_auto : v.exp_fixed;
  endfunction

  initial begin
    int strobes, valid_k;
    rst         = 1'b1;
    sample_tick = 1'b0;
    gate_in     = '0;
    env_in      = '0;
    phase_in    = '0;
    for (int a = 0; a < 256; a++) sine_mem[a] = 16'h0000;

    //          gate   env       base   fill      first     auto      fixed     count
    vecs[0] = '{8'h01, 16'hFFFF, 8'h40, 16'h1234, 16'hFFFF, 16'hFFFE, 16'h1FFF, 4'd1};
    vecs[1] = '{8'h07, 16'hFFFF, 8'h00, 16'h8000, 16'h8000, 16'h5FFF, 16'h2FFF, 4'd3};
    vecs[2] = '{8'h00, 16'hFFFF, 8'h20, 16'h8000, 16'h8000, 16'h0000, 16'h0000, 4'd0};
    vecs[3] = '{8'hFF, 16'h8000, 8'h10, 16'h8000, 16'h8000, 16'h4000, 16'h4000, 4'd8};
    vecs[4] = '{8'h0A, 16'h4000, 8'h80, 16'hFFFF, 16'h1111, 16'h3FFF, 16'h0FFF, 4'd2};
    vecs[5] = '{8'h1F, 16'hFFFF, 8'hC0, 16'h1000, 16'hF000, 16'h25FF, 16'h25FF, 4'd5};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset.sample", 32'(sample_out), 32'd0);
    check("reset.valid", 32'(sample_valid_out), 32'd0);
    check("reset.busy", 32'(busy_out), 32'd0);
    check("reset.overrun", 32'(overrun_out), 32'd0);
    check("reset.count", 32'(active_count_out), 32'd0);
    check("reset.addr", 32'(addr_out), 32'd0);

    for (int i = 0; i < 6; i++) begin
      load_vec(vecs[i]);
      run_mix($sformatf("vec%0d", i), vecs[i].base, pick(vecs[i]), vecs[i].exp_count, 0);
    end
    check("no_overrun", 32'(overrun_out), 32'd0);

    load_vec(vecs[1]);
    run_mix("overrun", vecs[1].base, pick(vecs[1]), vecs[1].exp_count, 5);
    check("overrun.set", 32'(overrun_out), 32'd1);
    load_vec(vecs[0]);
    run_mix("post_overrun", vecs[0].base, pick(vecs[0]), vecs[0].exp_count, 0);
    check("overrun.sticky", 32'(overrun_out), 32'd1);

    // Reset at T+6 aborts the mix; a tick at T+10 must strobe at T+23.
    load_vec(vecs[1]);
    strobes = 0;
    valid_k = -1;
    @(negedge clk);
    sample_tick = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1 || k == 11) sample_tick = 1'b0;
      if (k == 6) rst = 1'b1;
      if (k == 7) rst = 1'b0;
      if (sample_valid_out) begin
        if (k < 10) strobes++;
        else if (valid_k < 0) valid_k = k;
      end
      if (k == 8) begin
        check("abort.sample", 32'(sample_out), 32'd0);
        check("abort.busy", 32'(busy_out), 32'd0);
        check("abort.count", 32'(active_count_out), 32'd0);
        check("abort.overrun", 32'(overrun_out), 32'd0);
      end
      if (k == 10) sample_tick = 1'b1;
    end
    check("abort.no_strobe", 32'(strobes), 32'd0);
    check("abort.retry_cycle", 32'(valid_k), 32'd23);
    check("abort.retry_sample", 32'(sample_out), 32'(pick(vecs[1])));
    check("abort.retry_count", 32'(active_count_out), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
